// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: access sizes,
// FSM states, the peripheral window default and load lane handling.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_RAM,
        S_PERIPH,
        S_FAULT,
        S_RESP
    } state_e;

    localparam logic [3:0] PERIPH_BASE_DEFAULT = 4'h4;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [1:0]  size,
                                                 input logic        lsigned);
        logic [31:0] sh;
        sh = word >> {addr_lo, 3'b000};
        case (size)
            SZ_BYTE: return {{24{lsigned & sh[7]}}, sh[7:0]};
            SZ_HALF: return {{16{lsigned & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return 4'b0011 << addr_lo;
            SZ_WORD: return 4'hF;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Contents are never reset so the array maps onto block RAM.
module dmem_ram #(
    parameter  int RAM_WORDS = 1024,
    localparam int AW        = $clog2(RAM_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: decodes load/store accesses into internal RAM, the
// peripheral window or a fault, with RAM wait states and peripheral timeout.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int         RAM_WORDS   = 1024,
    parameter int         WAIT_STATES = 0,
    parameter logic [3:0] PERIPH_BASE = PERIPH_BASE_DEFAULT,
    parameter int         TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        lsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        fault,
    output logic        busy,
    output logic        periph_req,
    output logic        periph_we,
    output logic [31:0] periph_addr,
    output logic [31:0] periph_wdata,
    output logic [3:0]  periph_be,
    input  logic [31:0] periph_rdata,
    input  logic        periph_ack
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    state_e        state_q, state_d;
    logic          we_q, lsigned_q, fault_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, wdata_q, wdata_rep, ram_rdata;
    logic [3:0]    be_q, ram_be;
    logic [2:0]    wcnt;
    logic [TW-1:0] tcnt;
    logic          misaligned, ram_hit, periph_hit, wait_done, timed_out;

    always_comb begin
        case (size)
            SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    assign misaligned = (size_q == 2'd3)
                     || (size_q == SZ_HALF && addr_q[0])
                     || (size_q == SZ_WORD && addr_q[1:0] != 2'b00);
    assign ram_hit    = {1'b0, addr_q} < RAM_BYTES;
    assign periph_hit = addr_q[31:28] == PERIPH_BASE;
    assign wait_done  = wcnt == 3'(WAIT_STATES);
    assign timed_out  = tcnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req) state_d = S_DECODE;
            S_DECODE: begin
                if (misaligned)      state_d = S_FAULT;
                else if (ram_hit)    state_d = S_RAM;
                else if (periph_hit) state_d = S_PERIPH;
                else                 state_d = S_FAULT;
            end
            S_RAM:    if (wait_done) state_d = S_RESP;
            // First PERIPH cycle raises periph_req; an ack in the expiry cycle wins.
            S_PERIPH: begin
                if (periph_req) begin
                    if (periph_ack)     state_d = S_RESP;
                    else if (timed_out) state_d = S_FAULT;
                end
            end
            S_FAULT:  state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign ack   = state_q == S_RESP;
    assign fault = ack & fault_q;
    assign busy  = state_q != S_IDLE;

    assign periph_we    = we_q;
    assign periph_addr  = {addr_q[31:2], 2'b00};
    assign periph_wdata = wdata_q;
    assign periph_be    = be_q;

    // Write lands on the edge into RESP; a reset on that edge suppresses it.
    assign ram_be = (state_q == S_RAM && wait_done && we_q && !reset) ? be_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            lsigned_q  <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata      <= '0;
            fault_q    <= 1'b0;
            periph_req <= 1'b0;
            wcnt       <= '0;
            tcnt       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q      <= we;
                        lsigned_q <= lsigned;
                        size_q    <= size;
                        addr_q    <= addr;
                        wdata_q   <= wdata_rep;
                        be_q      <= byte_enables(size, addr[1:0]);
                    end
                end
                S_DECODE: begin
                    wcnt    <= '0;
                    fault_q <= 1'b0;
                end
                S_RAM: begin
                    if (wait_done) rdata <= lane_extract(ram_rdata, addr_q[1:0], size_q, lsigned_q);
                    else           wcnt  <= wcnt + 3'd1;
                end
                S_PERIPH: begin
                    if (!periph_req) begin
                        periph_req <= 1'b1;
                        tcnt       <= '0;
                    end else if (periph_ack) begin
                        periph_req <= 1'b0;
                        rdata      <= lane_extract(periph_rdata, addr_q[1:0], size_q, lsigned_q);
                    end else if (timed_out) begin
                        periph_req <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_FAULT: begin
                    rdata   <= '0;
                    fault_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    dmem_ram #(.RAM_WORDS(RAM_WORDS)) u_ram (
        .clk   (clk),
        .be    (ram_be),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, reset corner cases and a
// randomized phase checked against a byte-level behavioural model.
module tb_data_mem_ctrl;

    localparam int WS   = 2;
    localparam int TO   = 4;
    localparam int NW   = 64;
    localparam int NRND = 400;

    logic        clk = 1'b0;
    logic        reset, req, we, lsigned, periph_ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, periph_rdata;
    logic [31:0] rdata, periph_addr, periph_wdata;
    logic        ack, fault, busy, periph_req, periph_we;
    logic [3:0]  periph_be;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [NW*4];

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .RAM_WORDS   (NW),
        .WAIT_STATES (WS),
        .PERIPH_BASE (4'h4),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .we           (we),
        .size         (size),
        .lsigned      (lsigned),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .ack          (ack),
        .fault        (fault),
        .busy         (busy),
        .periph_req   (periph_req),
        .periph_we    (periph_we),
        .periph_addr  (periph_addr),
        .periph_wdata (periph_wdata),
        .periph_be    (periph_be),
        .periph_rdata (periph_rdata),
        .periph_ack   (periph_ack)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    endfunction

    function automatic bit m_is_ram(input logic [31:0] a);
        return a < NW * 4;
    endfunction

    function automatic bit m_is_per(input logic [31:0] a);
        return (a >> 28) == 4;
    endfunction

    function automatic bit m_bad_shape(input logic [1:0] sz, input logic [31:0] a);
        int n = m_nbytes(sz);
        if (n == 0) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] m_extend(input logic [31:0] v, input int n, input bit sg);
        if (n == 4) return v;
        if (sg && v >= (32'd1 << (8*n - 1))) return v - (32'd1 << (8*n));
        return v;
    endfunction

    function automatic bit m_per_ok(input int pd);
        return pd >= 0 && pd < TO;
    endfunction

    task automatic m_predict(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input int pd, input logic [31:0] pdat,
                             output logic f, output int lat, output bit chk, output logic [31:0] rd);
        int n = m_nbytes(sz);
        logic [31:0] v;
        f = 1'b0; lat = WS + 2; chk = !w; rd = '0;
        if (m_bad_shape(sz, a) || !(m_is_ram(a) || m_is_per(a))) begin
            f = 1'b1; lat = 2; chk = 1'b1;
        end else if (m_is_ram(a)) begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(mem_m[a + i]) << (8*i));
            rd = m_extend(v, n, sg);
        end else if (m_per_ok(pd)) begin
            lat = 3 + pd;
            v = pdat >> (8 * (a % 4));
            if (n < 4) v = v & ((32'd1 << (8*n)) - 1);
            rd = m_extend(v, n, sg);
        end else begin
            f = 1'b1; lat = TO + 3; chk = 1'b1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int pd, input logic [31:0] pdat, input bit junk, input bit noise,
                             output logic [31:0] got_rd, output logic got_f, output int lat,
                             output int pcyc, output int pfirst,
                             output logic [31:0] p_addr, output logic [31:0] p_wdata,
                             output logic [3:0] p_be, output logic p_we, output bit proto_bad);
        req = 1'b1; we = w; size = sz; lsigned = sg; addr = a; wdata = wd;
        @(posedge clk); #1;
        if (junk) begin
            we = 1'b1; size = 2'd2; addr = 32'h0; wdata = 32'hBAD0BAD0;
        end else begin
            req = 1'b0;
        end
        lat = -1; pcyc = 0; pfirst = -1; got_rd = '0; got_f = 1'b0;
        p_addr = '0; p_wdata = '0; p_be = '0; p_we = 1'b0;
        proto_bad = !busy;
        for (int c = 1; c <= 50 && lat < 0; c++) begin
            @(posedge clk); #1;
            periph_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            periph_rdata = $urandom;
            if (!busy) proto_bad = 1'b1;
            if (ack) begin
                lat = c; got_rd = rdata; got_f = fault;
            end else if (periph_req) begin
                if (pfirst < 0) begin
                    pfirst = c; p_addr = periph_addr; p_wdata = periph_wdata;
                    p_be = periph_be; p_we = periph_we;
                end
                if (pcyc == pd) begin
                    periph_ack = 1'b1; periph_rdata = pdat;
                end
                pcyc++;
            end
        end
        req = 1'b0; periph_ack = 1'b0;
        @(posedge clk); #1;
        if (ack || busy) proto_bad = 1'b1;
    endtask

    task automatic run_access(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input int pd,
                              input logic [31:0] pdat, input bit junk,
                              input logic exp_f, input int exp_lat, input bit chk_rd,
                              input logic [31:0] exp_rd);
        logic [31:0] got_rd, p_addr, p_wdata, exp_wd;
        logic        got_f, p_we;
        logic [3:0]  p_be;
        int          lat, pcyc, pfirst, n;
        bit          proto_bad, per;
        n   = m_nbytes(sz);
        per = m_is_per(a) && !m_is_ram(a) && !m_bad_shape(sz, a);
        do_access(w, sz, sg, a, wd, pd, pdat, junk, !per, got_rd, got_f, lat, pcyc, pfirst,
                  p_addr, p_wdata, p_be, p_we, proto_bad);
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " fault"}, 32'(got_f), 32'(exp_f));
        if (chk_rd) check({nm, " rdata"}, got_rd, exp_rd);
        check({nm, " busy/ack pulse"}, 32'(proto_bad), 32'd0);
        check({nm, " periph_req cycles"}, 32'(pcyc), per ? (m_per_ok(pd) ? 32'(pd + 1) : 32'(TO)) : 32'd0);
        if (per) begin
            for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % n) +: 8];
            check({nm, " periph_req rise"}, 32'(pfirst), 32'd2);
            check({nm, " periph_addr"}, p_addr, a - (a % 4));
            check({nm, " periph_be"}, 32'(p_be), (((32'd1 << n) - 1) << (a % 4)) & 32'hF);
            check({nm, " periph_we"}, 32'(p_we), 32'(w));
            if (w) check({nm, " periph_wdata"}, p_wdata, exp_wd);
        end
        if (w && !exp_f && m_is_ram(a))
            for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, " ack"}, 32'(ack), 32'd0);
        check({tag, " fault"}, 32'(fault), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " periph_req"}, 32'(periph_req), 32'd0);
        check({tag, " periph_we"}, 32'(periph_we), 32'd0);
        check({tag, " rdata"}, rdata, 32'd0);
        check({tag, " periph_addr"}, periph_addr, 32'd0);
        check({tag, " periph_wdata"}, periph_wdata, 32'd0);
        check({tag, " periph_be"}, 32'(periph_be), 32'd0);
    endtask

    typedef struct {
        string       nm;
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        int          pd;
        logic [31:0] pdat;
        logic        exp_f;
        int          exp_lat;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic        ef;
        int          el, pd, kind, n;
        bit          ec, ack_seen;
        logic [31:0] er, a, wd;
        logic [1:0]  sz;

        reset = 1'b1; req = 1'b0; we = 1'b0; size = '0; lsigned = 1'b0;
        addr = '0; wdata = '0; periph_rdata = '0; periph_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        //          name        w     sz    sg    addr          wdata         pd  pdata        f     lat  chk   rdata
        tbl.push_back('{"st_w10",   1'b1, 2'd2, 1'b0, 32'h10,       32'hDEADBEEF, -1, 32'h0,       1'b0, 4,  1'b0, 32'h0});
        tbl.push_back('{"ld_w10",   1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        -1, 32'h0,       1'b0, 4,  1'b1, 32'hDEADBEEF});
        tbl.push_back('{"st_b13",   1'b1, 2'd0, 1'b0, 32'h13,       32'h00000080, -1, 32'h0,       1'b0, 4,  1'b0, 32'h0});
        tbl.push_back('{"ld_sb13",  1'b0, 2'd0, 1'b1, 32'h13,       32'h0,        -1, 32'h0,       1'b0, 4,  1'b1, 32'hFFFFFF80});
        tbl.push_back('{"ld_ub13",  1'b0, 2'd0, 1'b0, 32'h13,       32'h0,        -1, 32'h0,       1'b0, 4,  1'b1, 32'h00000080});
        tbl.push_back('{"st_w20",   1'b1, 2'd2, 1'b0, 32'h20,       32'h55667788, -1, 32'h0,       1'b0, 4,  1'b0, 32'h0});
        tbl.push_back('{"st_h22",   1'b1, 2'd1, 1'b0, 32'h22,       32'h00001234, -1, 32'h0,       1'b0, 4,  1'b0, 32'h0});
        tbl.push_back('{"ld_w20",   1'b0, 2'd2, 1'b0, 32'h20,       32'h0,        -1, 32'h0,       1'b0, 4,  1'b1, 32'h12347788});
        tbl.push_back('{"mis_h11",  1'b1, 2'd1, 1'b0, 32'h11,       32'h0000FFFF, -1, 32'h0,       1'b1, 2,  1'b1, 32'h0});
        tbl.push_back('{"mis_w12",  1'b0, 2'd2, 1'b0, 32'h12,       32'h0,        -1, 32'h0,       1'b1, 2,  1'b1, 32'h0});
        tbl.push_back('{"ld_w10b",  1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        -1, 32'h0,       1'b0, 4,  1'b1, 32'h80ADBEEF});
        tbl.push_back('{"ld_uh22",  1'b0, 2'd1, 1'b0, 32'h22,       32'h0,        -1, 32'h0,       1'b0, 4,  1'b1, 32'h00001234});
        tbl.push_back('{"st_wFC",   1'b1, 2'd2, 1'b0, 32'hFC,       32'hCAFEF00D, -1, 32'h0,       1'b0, 4,  1'b0, 32'h0});
        tbl.push_back('{"ld_wFC",   1'b0, 2'd2, 1'b0, 32'hFC,       32'h0,        -1, 32'h0,       1'b0, 4,  1'b1, 32'hCAFEF00D});
        tbl.push_back('{"ld_w100",  1'b0, 2'd2, 1'b0, 32'h100,      32'h0,        -1, 32'h0,       1'b1, 2,  1'b1, 32'h0});
        tbl.push_back('{"size3",    1'b0, 2'd3, 1'b0, 32'h0,       32'h0,        -1, 32'h0,       1'b1, 2,  1'b1, 32'h0});
        tbl.push_back('{"unmapped", 1'b0, 2'd2, 1'b0, 32'h50000000, 32'h0,        -1, 32'h0,       1'b1, 2,  1'b1, 32'h0});
        tbl.push_back('{"per_rd",   1'b0, 2'd2, 1'b0, 32'h40000004, 32'h0,         3, 32'h000000A5, 1'b0, 6,  1'b1, 32'h000000A5});
        tbl.push_back('{"per_to",   1'b0, 2'd2, 1'b0, 32'h40000008, 32'h0,        -1, 32'h0,       1'b1, 7,  1'b1, 32'h0});
        tbl.push_back('{"per_late", 1'b0, 2'd2, 1'b0, 32'h4000000C, 32'h0,         4, 32'h12345678, 1'b1, 7,  1'b1, 32'h0});
        tbl.push_back('{"per_sh",   1'b0, 2'd1, 1'b1, 32'h40000002, 32'h0,         0, 32'h80011234, 1'b0, 3,  1'b1, 32'hFFFF8001});
        tbl.push_back('{"per_sb",   1'b1, 2'd0, 1'b0, 32'h40000101, 32'h000000C3,  1, 32'h0,       1'b0, 4,  1'b0, 32'h0});
        tbl.push_back('{"st_w30",   1'b1, 2'd2, 1'b0, 32'h30,       32'h11223344, -1, 32'h0,       1'b0, 4,  1'b0, 32'h0});
        tbl.push_back('{"ld_w30",   1'b0, 2'd2, 1'b0, 32'h30,       32'h0,        -1, 32'h0,       1'b0, 4,  1'b1, 32'h11223344});

        foreach (tbl[i])
            run_access(tbl[i].nm, tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, tbl[i].pd,
                       tbl[i].pdat, 1'b0, tbl[i].exp_f, tbl[i].exp_lat, tbl[i].chk_rd, tbl[i].exp_rd);

        // reset during the RAM wait of a store
        req = 1'b1; we = 1'b1; size = 2'd2; lsigned = 1'b0; addr = 32'h30; wdata = 32'h99999999;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("mid_reset");
        reset = 1'b0;
        ack_seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack) ack_seen = 1'b1;
        end
        check("mid_reset no ack", 32'(ack_seen), 32'd0);
        run_access("ld_w30_after_reset", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, -1, 32'h0, 1'b0,
                   1'b0, 4, 1'b1, 32'h11223344);

        for (int i = 0; i < NW; i++) begin
            wd = $urandom;
            run_access("init", 1'b1, 2'd2, 1'b0, 32'(4 * i), wd, -1, 32'h0, 1'b0, 1'b0, 4, 1'b0, 32'h0);
        end

        for (int i = 0; i < NRND; i++) begin
            kind = $urandom_range(0, 9);
            sz   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            n    = m_nbytes(sz);
            pd   = -1;
            wd   = $urandom;
            if (kind <= 5) begin
                a = 32'($urandom_range(0, NW * 4 - 1));
            end else if (kind <= 8) begin
                a  = {4'h4, 28'($urandom)};
                pd = $urandom_range(0, 5);
            end else begin
                a = $urandom_range(0, 1) ? 32'h100 + ($urandom & 32'hFFF) : {4'h5, 28'($urandom)};
            end
            if (n > 0 && $urandom_range(0, 3) != 0) a = a - (a % n);
            m_predict(1'($urandom_range(0, 1)), sz, 1'b0, a, pd, 32'h0, ef, el, ec, er);
            begin
                logic w, sg;
                logic [31:0] pdat;
                w = 1'($urandom_range(0, 1));
                sg = 1'($urandom_range(0, 1));
                pdat = $urandom;
                m_predict(w, sz, sg, a, pd, pdat, ef, el, ec, er);
                run_access("rand", w, sz, sg, a, wd, pd, pdat, 1'($urandom_range(0, 1)), ef, el, ec, er);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
